// File: rtl/brq_ifu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : brq_ifu_mem_arbiter
//  Brief    : Two-requester arbiter for the single instruction-memory port.
//             Port 0 is the prefetch buffer and port 1 is the debug/loader
//             fetch agent. A granted request's port ID is queued in order, so
//             each in-order memory response is routed back to its originator.
//  Options  : BRQ_IFU_ARB_RR_EN - round-robin arbitration. When it is not
//             defined, port 0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module brq_ifu_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0][31:0]  addr_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              busy_o
);

  localparam int unsigned c_ptr_w = $clog2(MaxOutstanding);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MaxOutstanding);

  // State registers
  logic [c_cnt_w-1:0]        count_q, count_d;
  logic [c_ptr_w-1:0]        wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]        rd_ptr_q, rd_ptr_d;
  logic [MaxOutstanding-1:0] id_fifo_q, id_fifo_d;
  logic                      lock_q, lock_d;
  logic                      lock_port_q, lock_port_d;
`ifdef BRQ_IFU_ARB_RR_EN
  logic                      prio_q, prio_d;
`endif

  // Combinational decisions
  logic        winner;
  logic        winner_valid;
  logic        full;
  logic        push;
  logic        pop;
  logic        head_id;
  logic [31:0] winner_addr;

  // Winner selection: a locked port keeps the memory port until granted.
  always_comb begin
    winner       = 1'b0;
    winner_valid = 1'b0;
    if (lock_q) begin
      winner       = lock_port_q;
      winner_valid = req_i[lock_port_q];
    end else begin
`ifdef BRQ_IFU_ARB_RR_EN
      if (req_i[prio_q]) begin
        winner       = prio_q;
        winner_valid = 1'b1;
      end else if (req_i[~prio_q]) begin
        winner       = ~prio_q;
        winner_valid = 1'b1;
      end
`else
      if (req_i[0]) begin
        winner       = 1'b0;
        winner_valid = 1'b1;
      end else if (req_i[1]) begin
        winner       = 1'b1;
        winner_valid = 1'b1;
      end
`endif
    end
  end

  // Request/response handshake and output drive; reset forces every output low.
  always_comb begin
    full        = (count_q == c_cnt_max);
    head_id     = id_fifo_q[rd_ptr_q];
    winner_addr = addr_i[winner];

    mem_req_o  = winner_valid & ~full & ~rst_i;
    mem_addr_o = rst_i ? 32'h0 : (winner_addr & 32'hFFFF_FFFC);
    push       = mem_req_o & mem_gnt_i;
    // A response with nothing outstanding is stray and must not underflow.
    pop        = mem_rvalid_i & (count_q != '0) & ~rst_i;

    gnt_o = 2'b00;
    if (push) begin
      gnt_o[winner] = 1'b1;
    end

    rvalid_o = 2'b00;
    if (pop) begin
      rvalid_o[head_id] = 1'b1;
    end

    rdata_o = rst_i ? 32'h0 : mem_rdata_i;
    err_o   = rst_i ? 1'b0  : mem_err_i;
    busy_o  = ~rst_i & ((count_q != '0) | mem_req_o);
  end

  // Next-state for ID FIFO, outstanding count, lock and priority pointer.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    id_fifo_d   = id_fifo_q;
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
`ifdef BRQ_IFU_ARB_RR_EN
    prio_d      = prio_q;
`endif

    if (push) begin
      id_fifo_d[wr_ptr_q] = winner;
      wr_ptr_d            = wr_ptr_q + c_ptr_w'(1);
`ifdef BRQ_IFU_ARB_RR_EN
      prio_d              = ~winner;
`endif
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end
    if (push && !pop) begin
      count_d = count_q + c_cnt_w'(1);
    end else if (!push && pop) begin
      count_d = count_q - c_cnt_w'(1);
    end

    // While the outstanding limit is reached the lock is frozen. Otherwise a
    // stalled request locks its port, a grant unlocks, and a locked port that
    // withdraws its request (no issue at all) also unlocks.
    if (!full) begin
      if (mem_req_o && !mem_gnt_i) begin
        lock_d      = 1'b1;
        lock_port_d = winner;
      end else begin
        lock_d      = 1'b0;
      end
    end
  end

  // State register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      id_fifo_q   <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
`ifdef BRQ_IFU_ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      id_fifo_q   <= id_fifo_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
`ifdef BRQ_IFU_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/brq_ifu_mem_arbiter.md
# brq_ifu_mem_arbiter

Two-requester arbiter sharing the single instruction-memory port between the prefetch buffer (port 0) and a secondary fetch agent (port 1, debug/loader). It grants one request per cycle, holds the selection stable while a request waits for grant, and tracks the requester ID of every granted transaction in order so each in-order response (rvalid/rdata/err) returns to its originator. It sits between the IFU request ports and the instruction memory/cache.

## Interface
Parameters:
- MaxOutstanding, 4: maximum granted-but-unanswered transactions on the memory port (power of two, ≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  2  per-port request; held with stable addr until that port's gnt_o
- addr_i  in  2x32  per-port request address
- gnt_o  out  2  per-port grant
- rvalid_o  out  2  per-port response valid
- rdata_o  out  32  response data, shared, qualified by rvalid_o
- err_o  out  1  response error, shared, qualified by rvalid_o
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  memory address, word-aligned ([1:0] forced 0)
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid, in request order
- mem_rdata_i  in  32  memory response data
- mem_err_i  in  1  memory response error
- busy_o  out  1  outstanding count ≠ 0 or mem_req_o

## Operation
- Selection: when not locked, winner chosen among req_i by priority (see Configuration); when locked, winner = locked port regardless of other requests.
- Lock: set at end of any cycle with mem_req_o=1 and mem_gnt_i=0 (lock_port = winner); cleared on the cycle mem_gnt_i=1. Guarantees mem_addr_o stable until grant.
- Issue gating: mem_req_o = winner valid and count < MaxOutstanding. When count = MaxOutstanding, mem_req_o=0, gnt_o=0, lock state unchanged; a same-cycle mem_rvalid_i does not bypass the limit.
- If the locked port drops req_i before grant (protocol violation), lock clears next cycle; no ID pushed.
- On mem_req_o & mem_gnt_i: gnt_o[winner]=1; winner ID pushed to ID FIFO (depth MaxOutstanding); count +1.
- On mem_rvalid_i: ID popped from FIFO head; rvalid_o[head]=1; rdata_o/err_o = mem_rdata_i/mem_err_i; count −1. Simultaneous push and pop: count unchanged, both pointers advance.
- mem_rvalid_i with count = 0: ignored, rvalid_o=0, count stays 0 (no underflow).
- Pointers wrap modulo MaxOutstanding; count width clog2(MaxOutstanding)+1.

## Timing
- Request path combinational: req_i/addr_i → mem_req_o/mem_addr_o same cycle; mem_gnt_i → gnt_o same cycle.
- Response path combinational: mem_rvalid_i → rvalid_o same cycle, zero latency.
- FIFO, count, lock, priority registers update on clk_i rising edge.
- Reset (rst_i=1 sampled at edge): count=0, pointers=0, lock cleared, priority pointer = port 0. While rst_i is high all outputs forced: mem_req_o=0, gnt_o=0, rvalid_o=0, busy_o=0, mem_addr_o=0, rdata_o=0, err_o=0. Reset mid-transaction discards all outstanding IDs; later stray mem_rvalid_i ignored per count-0 rule.

## Configuration
- BRQ_IFU_ARB_RR_EN defined: round-robin; priority pointer toggles to the other port after every grant, so on contention the port not granted last wins.
- Undefined: fixed priority, port 0 (prefetch buffer) always wins when unlocked; priority pointer absent.
- Lock, gating and response routing identical in both builds.

## Test plan
- Single port 0 request addr 0x0000_1006, mem_gnt_i same cycle, rvalid 2 cycles later rdata 0xDEADBEEF → mem_addr_o=0x0000_1004, gnt_o=01, then rvalid_o=01, rdata_o=0xDEADBEEF.
- Port 1 requests 0x200 with mem_gnt_i low 3 cycles, port 0 raises req at cycle 1 → mem_addr_o stays 0x200 until grant; port 0 granted on following cycle.
- Both ports request continuously, mem_gnt_i=1, immediate rvalid → RR build: grants alternate 01,10,01...; fixed build: only port 0 granted.
- Four grants without rvalid (MaxOutstanding=4) → 5th cycle mem_req_o=0, busy_o=1; one rvalid frees slot, request issues next cycle; responses return IDs in grant order.
- Simultaneous grant and rvalid with count=2 → count stays 2, correct ID routed; stray rvalid at count=0 → no rvalid_o.
- rst_i asserted with 3 outstanding → all outputs 0, busy_o=0 after reset, subsequent rvalid ignored.
